// File: rtl/noc_flit_pkg.sv
// NoC flit field layout, check codes and shared state encodings
// for the master-side read reorder path.
package noc_flit_pkg;

   localparam logic [3:0] HEAD_CODE_H = 4'hA;
   localparam logic [3:0] HEAD_CODE_E = 4'hB;
   localparam logic [3:0] TAIL_CODE_H = 4'hC;
   localparam logic [3:0] TAIL_CODE_E = 4'hD;

   localparam int CODE_W  = 4;
   localparam int TYPE_W  = 3;
   localparam int RSV_FIX = 8;

   // Offsets below assume the default 32b address, 4b IDs, 16 orders
   localparam int CODE_E_LSB = 0;
   localparam int ORDER_LSB  = CODE_E_LSB + CODE_W + RSV_FIX + 32;
   localparam int TYPE_LSB   = ORDER_LSB + 16;
   localparam int DEST_LSB   = TYPE_LSB + TYPE_W;
   localparam int SRC_LSB    = DEST_LSB + 4;
   localparam int CODE_H_MSB = SRC_LSB + 4 + CODE_W - 1;

   typedef enum logic [2:0] {
      WR_REQ  = 3'd0,
      RD_DATA = 3'd1,
      BRESP   = 3'd2
   } axi_type_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HEAD,
      W_BODY,
      W_DROP
   } wr_state_e;

   typedef enum logic {
      R_WAIT,
      R_STREAM
   } rd_state_e;

   function automatic int order_lsb(input int addr_w);
      return CODE_E_LSB + CODE_W + RSV_FIX + addr_w;
   endfunction

endpackage

// File: rtl/flit_slot_ram.sv
// Simple dual-port body-flit store, addressed {slot, index},
// with a registered read port that holds while re is low.
module flit_slot_ram
   import noc_flit_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/rd_reorder_seq.sv
// Read reorder buffer: parks each packet body in the slot named by its
// one-hot order and streams slots back out strictly in order.
module rd_reorder_seq
   import noc_flit_pkg::*;
#(
   parameter int DATA_WIDTH     = 128,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int ID_WIDTH       = 4,
   parameter int ORDER_NUM      = 16,
   parameter int FLIT_NUM_MAX   = 16
) (
   input  logic                  axi_clk,
   input  logic                  axi_rst,
   input  logic                  buffer_empty,
   output logic                  rd_data_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_head,
   input  logic                  rd_tail,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [ID_WIDTH-1:0]   out_dest_id,
   output logic [2:0]            out_type,
   output logic                  err_drop,
   output logic                  trans_done
);

   localparam int PTR_W  = $clog2(ORDER_NUM);
   localparam int IDX_W  = $clog2(FLIT_NUM_MAX);
   localparam int LEN_W  = $clog2(FLIT_NUM_MAX + 1);
   localparam int CNT_W  = PTR_W + 1;
   localparam int ADDR_W = PTR_W + IDX_W;
   localparam int O_LSB  = order_lsb(AXI_ADDR_WIDTH);
   localparam int T_LSB  = O_LSB + ORDER_NUM;
   localparam int D_LSB  = T_LSB + TYPE_W;
   localparam int H_LSB  = D_LSB + 2 * ID_WIDTH;

   function automatic logic [PTR_W-1:0] oh2bin(
      input logic [ORDER_NUM-1:0] oh
   );
      logic [PTR_W-1:0] b;
      b = '0;
      for (int i = 0; i < ORDER_NUM; i++) begin
         if (oh[i]) b = PTR_W'(i);
      end
      return b;
   endfunction

   wr_state_e wstate, w_next;
   rd_state_e rstate, r_next;

   logic [ORDER_NUM-1:0] full, set_vec, clr_vec;
   logic [LEN_W-1:0]     len [ORDER_NUM];
   logic [ID_WIDTH-1:0]  dest_mem [ORDER_NUM];
   logic [TYPE_W-1:0]    type_mem [ORDER_NUM];
   logic [PTR_W-1:0]     w_idx, exp_ptr, ord_idx;
   logic [LEN_W-1:0]     cnt, rptr, rptr_nx, slot_len;
   logic [CNT_W-1:0]     total, pack_num;
   logic                 total_known;

   logic [3:0]           code_h, code_e;
   logic [ORDER_NUM-1:0] ord_f;
   logic [ID_WIDTH-1:0]  dest_f;
   logic [TYPE_W-1:0]    type_f;
   logic                 head_ok, tail_code_ok, ord_onehot, all_full;
   logic                 take_head, tail_fin, ram_we, drop;
   logic                 rd_en, hs, adv, pkt_end, last_pkt, beat_end;
   logic                 slot_end, meta_load;
   logic                 unused_flit;

   assign code_h   = rd_data[H_LSB +: CODE_W];
   assign code_e   = rd_data[CODE_E_LSB +: CODE_W];
   assign ord_f    = rd_data[O_LSB +: ORDER_NUM];
   assign pack_num = rd_data[O_LSB +: CNT_W];
   assign dest_f   = rd_data[D_LSB +: ID_WIDTH];
   assign type_f   = rd_data[T_LSB +: TYPE_W];
   assign unused_flit = ^rd_data;

   assign ord_onehot = (ord_f != '0) && ((ord_f & (ord_f - 1'b1)) == '0);
   assign ord_idx    = oh2bin(ord_f);
   assign all_full   = &full;
   assign head_ok    = rd_head && code_h == HEAD_CODE_H
                    && code_e == HEAD_CODE_E && ord_onehot
                    && !full[ord_idx];
   assign tail_code_ok = code_h == TAIL_CODE_H && code_e == TAIL_CODE_E;

   // A full buffer leaves the next head parked in the FIFO
   assign rd_data_en = (wstate != W_IDLE) && !buffer_empty
                    && !(wstate == W_HEAD && all_full);

   always_comb begin
      w_next    = wstate;
      take_head = 1'b0;
      tail_fin  = 1'b0;
      ram_we    = 1'b0;
      drop      = 1'b0;
      unique case (wstate)
         W_IDLE: begin
            if (!buffer_empty) w_next = W_HEAD;
         end
         W_HEAD: begin
            if (rd_data_en && rd_head) begin
               if (head_ok) begin
                  take_head = 1'b1;
                  w_next    = W_BODY;
               end else begin
                  drop   = 1'b1;
                  w_next = W_DROP;
               end
            end
         end
         W_BODY: begin
            if (rd_data_en) begin
               if (rd_head) begin
                  drop = 1'b1;
                  if (head_ok) take_head = 1'b1;
                  else w_next = W_DROP;
               end else if (rd_tail) begin
                  tail_fin = tail_code_ok;
                  drop     = !tail_code_ok;
                  w_next   = W_IDLE;
               end else if (cnt == LEN_W'(FLIT_NUM_MAX)) begin
                  drop   = 1'b1;
                  w_next = W_DROP;
               end else begin
                  ram_we = 1'b1;
               end
            end
         end
         W_DROP: begin
            if (rd_data_en && rd_tail) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         wstate   <= W_IDLE;
         w_idx    <= '0;
         cnt      <= '0;
         err_drop <= 1'b0;
      end else begin
         wstate   <= w_next;
         err_drop <= drop;
         if (take_head) begin
            w_idx <= ord_idx;
            cnt   <= '0;
         end else if (ram_we) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign slot_len = len[exp_ptr];
   assign hs       = out_valid && out_ready;
   assign adv      = !out_valid || out_ready;
   assign rptr_nx  = rptr + 1'b1;
   assign beat_end = rptr_nx == slot_len;
   assign last_pkt = total_known
                  && ({1'b0, exp_ptr} == total - 1'b1);
   assign meta_load = rstate == R_WAIT && exp_ptr == '0 && full[0];

   always_comb begin
      r_next  = rstate;
      rd_en   = 1'b0;
      pkt_end = 1'b0;
      unique case (rstate)
         R_WAIT: begin
            if (full[exp_ptr]) begin
               if (slot_len == '0) pkt_end = 1'b1;
               else r_next = R_STREAM;
            end
         end
         R_STREAM: begin
            rd_en = adv && rptr != slot_len;
            if (hs && slot_end) begin
               pkt_end = 1'b1;
               r_next  = R_WAIT;
            end
         end
         default: r_next = R_WAIT;
      endcase
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (tail_fin) set_vec[w_idx] = 1'b1;
      if (pkt_end) clr_vec[exp_ptr] = 1'b1;
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         rstate      <= R_WAIT;
         rptr        <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         slot_end    <= 1'b0;
         trans_done  <= 1'b0;
         out_dest_id <= '0;
         out_type    <= '0;
      end else begin
         rstate     <= r_next;
         trans_done <= pkt_end && last_pkt;
         if (rstate == R_WAIT) rptr <= '0;
         else if (rd_en) rptr <= rptr_nx;
         if (rd_en) begin
            out_valid <= 1'b1;
            slot_end  <= beat_end;
            out_last  <= beat_end && last_pkt;
         end else if (hs) begin
            out_valid <= 1'b0;
            slot_end  <= 1'b0;
            out_last  <= 1'b0;
         end
         if (meta_load) begin
            out_dest_id <= dest_mem[0];
            out_type    <= type_mem[0];
         end
      end
   end

   // Slot bookkeeping shared by both FSMs; set and clear never collide
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         full        <= '0;
         len         <= '{default: '0};
         dest_mem    <= '{default: '0};
         type_mem    <= '{default: '0};
         exp_ptr     <= '0;
         total       <= '0;
         total_known <= 1'b0;
      end else begin
         full <= (full & ~clr_vec) | set_vec;
         if (tail_fin) len[w_idx] <= cnt;
         if (take_head) begin
            dest_mem[ord_idx] <= dest_f;
            type_mem[ord_idx] <= type_f;
         end
         if (pkt_end) exp_ptr <= last_pkt ? '0 : exp_ptr + 1'b1;
         if (pkt_end && last_pkt) total_known <= 1'b0;
         if (tail_fin && (!total_known || (pkt_end && last_pkt))) begin
            total       <= pack_num;
            total_known <= 1'b1;
         end
      end
   end

   flit_slot_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (ORDER_NUM * FLIT_NUM_MAX),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk   (axi_clk),
      .rst   (axi_rst),
      .we    (ram_we),
      .waddr ({w_idx, cnt[IDX_W-1:0]}),
      .wdata (rd_data),
      .re    (rd_en),
      .raddr ({exp_ptr, rptr[IDX_W-1:0]}),
      .rdata (out_data)
   );

endmodule

// File: tb/tb_rd_reorder_seq.sv
// Scoreboard bench for rd_reorder_seq: a FIFO model feeds flits,
// a negedge monitor checks every presented beat against a queue.
module tb_rd_reorder_seq;

   typedef struct packed {
      logic         h;
      logic         t;
      logic [127:0] d;
   } flit_t;

   typedef struct {
      logic [127:0] d;
      logic         last;
      logic [3:0]   dest;
      logic [2:0]   ty;
   } exp_t;

   logic         clk = 1'b0;
   logic         axi_rst = 1'b1;
   logic         buffer_empty = 1'b1;
   logic         rd_data_en;
   logic [127:0] rd_data = '0;
   logic         rd_head = 1'b0;
   logic         rd_tail = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_last;
   logic [3:0]   out_dest_id;
   logic [2:0]   out_type;
   logic         err_drop;
   logic         trans_done;

   flit_t fifo[$];
   exp_t  exp_q[$];
   int    total_n = 0;
   int    bad_n = 0;
   int    drops = 0;
   int    dones = 0;
   logic  pop_pend = 1'b0;
   logic  td_pend = 1'b0;
   logic  rnd = 1'b0;

   rd_reorder_seq dut (
      .axi_clk      (clk),
      .axi_rst      (axi_rst),
      .buffer_empty (buffer_empty),
      .rd_data_en   (rd_data_en),
      .rd_data      (rd_data),
      .rd_head      (rd_head),
      .rd_tail      (rd_tail),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_dest_id  (out_dest_id),
      .out_type     (out_type),
      .err_drop     (err_drop),
      .trans_done   (trans_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [3:0] ch,
      input logic [3:0] dest, input logic [2:0] ty,
      input logic [15:0] ord, input logic [3:0] ce);
      logic [127:0] f;
      f = '0;
      f[74:71] = ch;
      f[70:67] = 4'h1;
      f[66:63] = dest;
      f[62:60] = ty;
      f[59:44] = ord;
      f[3:0]   = ce;
      return f;
   endfunction

   function automatic logic [127:0] body(input int tag);
      logic [127:0] b;
      b = '0;
      b[127:96] = 32'hB0D1_0000;
      b[7:0]    = tag[7:0];
      return b;
   endfunction

   task automatic push_pkt(input int ord, input int nb, input int num,
      input logic [3:0] dest, input logic [2:0] ty, input int tag0,
      input logic [3:0] hce);
      logic [15:0] oh;
      oh = 16'(1 << ord);
      fifo.push_back('{1'b1, 1'b0, mk(4'hA, dest, ty, oh, hce)});
      for (int i = 0; i < nb; i++)
         fifo.push_back('{1'b0, 1'b0, body(tag0 + i)});
      fifo.push_back('{1'b0, 1'b1, mk(4'hC, dest, ty, 16'(num), 4'hD)});
   endtask

   task automatic exp_pkt(input int tag0, input int nb, input logic lastp,
      input logic [3:0] dest, input logic [2:0] ty);
      exp_t e;
      for (int i = 0; i < nb; i++) begin
         e.d    = body(tag0 + i);
         e.last = lastp && (i == nb - 1);
         e.dest = dest;
         e.ty   = ty;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_fifo(input string nm);
      int n;
      n = 0;
      while (fifo.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (6) @(posedge clk);
      chk({nm, " fifo drained"}, 128'(fifo.size()), 0);
   endtask

   task automatic wait_done(input string nm, input int want);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || dones != want) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      chk({nm, " beats left"}, 128'(exp_q.size()), 0);
      chk({nm, " trans_done count"}, 128'(dones), 128'(want));
   endtask

   task automatic chk_idle(input string nm);
      @(negedge clk);
      chk({nm, " out_valid"}, out_valid, 0);
      chk({nm, " out_last"}, out_last, 0);
      chk({nm, " out_data"}, out_data, 0);
      chk({nm, " out_dest_id"}, out_dest_id, 0);
      chk({nm, " out_type"}, out_type, 0);
      chk({nm, " err_drop"}, err_drop, 0);
      chk({nm, " trans_done"}, trans_done, 0);
      chk({nm, " rd_data_en"}, rd_data_en, 0);
   endtask

   // FIFO model: pop decided at negedge, applied just after posedge
   initial forever begin
      @(negedge clk);
      pop_pend = rd_data_en;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
      buffer_empty = fifo.size() == 0;
      if (fifo.size() > 0) begin
         rd_head = fifo[0].h;
         rd_tail = fifo[0].t;
         rd_data = fifo[0].d;
      end else begin
         rd_head = 1'b0;
         rd_tail = 1'b0;
         rd_data = '0;
      end
      out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (!axi_rst) begin
         if (td_pend || trans_done)
            chk("trans_done after last", trans_done, td_pend);
         td_pend = 1'b0;
         if (err_drop) drops++;
         if (trans_done) dones++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected beat", out_data, 0);
            end else begin
               chk("out_data", out_data, exp_q[0].d);
               chk("out_last", out_last, exp_q[0].last);
               chk("out_dest_id", out_dest_id, exp_q[0].dest);
               chk("out_type", out_type, exp_q[0].ty);
               if (out_ready) begin
                  td_pend = exp_q[0].last;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 axi_rst = 1'b0;
      chk_idle("reset");

      // 1: in order, two bodies each
      for (int p = 0; p < 4; p++)
         push_pkt(p, 2, 4, (p == 0) ? 4'h5 : 4'(p + 8), 3'd1, p * 16, 4'hB);
      for (int p = 0; p < 4; p++)
         exp_pkt(p * 16, 2, p == 3, 4'h5, 3'd1);
      wait_done("t1", 1);
      chk("t1 err_drop count", 128'(drops), 0);

      // 2: arrival 2,0,3,1; nothing may leave before slot 0
      push_pkt(2, 2, 4, 4'h2, 3'd1, 8'h20, 4'hB);
      wait_fifo("t2a");
      chk("t2 idle before slot0", out_valid, 0);
      push_pkt(0, 2, 4, 4'h7, 3'd1, 8'h00, 4'hB);
      push_pkt(3, 2, 4, 4'h3, 3'd1, 8'h30, 4'hB);
      push_pkt(1, 2, 4, 4'h1, 3'd1, 8'h10, 4'hB);
      for (int p = 0; p < 4; p++)
         exp_pkt(p * 16, 2, p == 3, 4'h7, 3'd1);
      wait_done("t2", 2);

      // 3: same sequence under random backpressure
      rnd = 1'b1;
      push_pkt(2, 2, 4, 4'h2, 3'd1, 8'h20, 4'hB);
      push_pkt(0, 2, 4, 4'h9, 3'd1, 8'h00, 4'hB);
      push_pkt(3, 2, 4, 4'h3, 3'd1, 8'h30, 4'hB);
      push_pkt(1, 2, 4, 4'h1, 3'd1, 8'h10, 4'hB);
      for (int p = 0; p < 4; p++)
         exp_pkt(p * 16, 2, p == 3, 4'h9, 3'd1);
      wait_done("t3", 3);
      rnd = 1'b0;

      // 4: bad code, duplicate order, oversized body, then good packet
      push_pkt(0, 1, 2, 4'h4, 3'd1, 8'hEE, 4'hF);
      push_pkt(1, 1, 2, 4'h6, 3'd1, 8'h50, 4'hB);
      push_pkt(1, 1, 2, 4'h6, 3'd1, 8'hEF, 4'hB);
      push_pkt(0, 17, 2, 4'h4, 3'd1, 8'h60, 4'hB);
      push_pkt(0, 2, 2, 4'h3, 3'd1, 8'h40, 4'hB);
      exp_pkt(8'h40, 2, 1'b0, 4'h3, 3'd1);
      exp_pkt(8'h50, 1, 1'b1, 4'h3, 3'd1);
      wait_done("t4", 4);
      chk("t4 err_drop count", 128'(drops), 3);
      chk("t4 all popped", 128'(fifo.size()), 0);

      // 5: zero-length slot 0
      push_pkt(0, 0, 2, 4'hA, 3'd2, 0, 4'hB);
      push_pkt(1, 3, 2, 4'hC, 3'd2, 8'h70, 4'hB);
      exp_pkt(8'h70, 3, 1'b1, 4'hA, 3'd2);
      wait_done("t5", 5);

      // 6: reset in the middle of a body
      push_pkt(1, 1, 2, 4'h2, 3'd1, 8'h90, 4'hB);
      fifo.push_back('{1'b1, 1'b0, mk(4'hA, 4'h2, 3'd1, 16'h0001, 4'hB)});
      fifo.push_back('{1'b0, 1'b0, body(8'h91)});
      wait_fifo("t6a");
      @(posedge clk);
      #1 axi_rst = 1'b1;
      @(posedge clk);
      #1 axi_rst = 1'b0;
      chk_idle("t6 reset");
      fifo.push_back('{1'b0, 1'b0, body(8'h92)});
      fifo.push_back('{1'b0, 1'b1, mk(4'hC, 4'h2, 3'd1, 16'd2, 4'hD)});
      push_pkt(0, 1, 2, 4'hB, 3'd1, 8'hA0, 4'hB);
      push_pkt(1, 1, 2, 4'h2, 3'd1, 8'hA1, 4'hB);
      exp_pkt(8'hA0, 1, 1'b0, 4'hB, 3'd1);
      exp_pkt(8'hA1, 1, 1'b1, 4'hB, 3'd1);
      wait_done("t6", 6);
      chk("t6 err_drop count", 128'(drops), 3);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
